mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage sitting directly downstream of the EX/MEM pipeline register; consumes its outputs.
- Performs loads and stores against a data memory with a ready-based wait handshake.
- Stalls upstream while memory is busy; aligns and extends load data.
- Registers the results into the MEM/WB-side outputs consumed by write-back.

Parameters:
- TIMEOUT, 16, max WAIT cycles before a bus-timeout abort (≥1).
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- memtoreg_in  in  1  load op
- regwrite_in  in  1  register write enable
- memwrite_in  in  4  store byte mask at offset 0: 0001 SB, 0011 SH, 1111 SW, 0000 none
- ALUout_in  in  32  effective address / ALU result
- rdata2_in  in  32  store data
- invalid_in  in  1  bubble marker
- immgen_in  in  32  immediate, passed through
- regin_in  in  2  write-back mux select, passed through
- PC_plus4_in  in  32  passed through
- inst_data_in  in  32  instruction; [14:12] = load funct3
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_be  out  4  lane enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- stall_out  out  1  hold EX/MEM and earlier stages
- regwrite_out, memtoreg_out  out  1 each  registered
- regin_out  out  2  registered
- ALUout_out, immgen_out, PC_plus4_out, inst_data_out  out  32 each  registered
- load_data_out  out  32  aligned/extended load data
- invalid_out  out  1  registered bubble flag
- exc_out  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - While rst=1: FSM=IDLE, counter=0, dmem_req=0, all registered outputs 0 except invalid_out=1.
  - Reset mid-WAIT drops dmem_req immediately.
- Memory op (memop): invalid_in=0 and (memtoreg_in=1 or memwrite_in≠0).
- Illegal (exc 11), no access issued, when any of:
  - memtoreg_in=1 and memwrite_in≠0;
  - memwrite_in ∉ {0000,0001,0011,1111};
  - load funct3 ∈ {011,110,111}.
- Misaligned (exc 01), no access issued:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00.
- Store lanes: dmem_be = memwrite_in << addr[1:0]; dmem_wdata = rdata2_in << (8*addr[1:0]).
- Load lanes: byte/half selected by addr[1:0].
  - funct3 000 LB and 001 LH sign-extend.
  - 100 LBU and 101 LHU zero-extend.
  - 010 LW passes the word through.
- FSM IDLE:
  - If memop and legal and aligned: drive dmem_req=1 combinationally from the inputs.
  - If dmem_ready=1 in the same cycle: zero-wait completion; outputs capture at this edge; stall_out=0.
  - Otherwise: stall_out=1, latch the request into internal registers, go to WAIT with counter=0.
- FSM WAIT:
  - dmem_req and its fields come from the latched registers and stay stable.
  - stall_out=1; counter increments every cycle.
  - dmem_ready=1: capture the result, stall_out=0 this cycle, go to IDLE.
  - Counter reaches TIMEOUT without ready: deassert req, exc_out=10, go to IDLE.
  - Ready in the same cycle as the timeout: ready wins.
- Stall cycles: outputs are loaded as a bubble (invalid_out=1, regwrite_out=0, memtoreg_out=0).
- Completion or non-memop: all passthroughs registered with 1-cycle latency.
- Any exception: regwrite_out=0, invalid_out=1, exc_out set for exactly one cycle.
- Non-memop instructions never assert dmem_req and never stall.
- invalid_in=1 is passed through as a bubble, exc_out=00.

Decomposition:
- Package mem_stage_pkg:
  - exc_e enum {EXC_NONE, EXC_MISALIGN, EXC_TIMEOUT, EXC_ILLEGAL};
  - load funct3 localparams;
  - BE_B/BE_H/BE_W masks;
  - state_e {IDLE, WAIT}.
- Sub-module load_align: combinational; takes rdata, addr[1:0], funct3; returns the 32-bit extended value.

Test Plan:
- LW addr 0x100, ready held 1, rdata 0xDEADBEEF → one access, no stall; next cycle load_data_out=0xDEADBEEF, regwrite_out=1.
- LB addr 0x103, rdata 0x80FF_0000 → load_data_out=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SH addr 0x202, rdata2 0x0000ABCD, ready after 3 cycles → dmem_be=1100, wdata=0xABCD0000, dmem_addr=0x200; stall_out high 3 cycles with bubbles, then completion.
- LW addr 0x101 → no dmem_req; exc_out=01, regwrite_out=0, invalid_out=1; SW addr 0x106 → same.
- LW, ready never asserted, TIMEOUT=16 → stall for 16 cycles, exc_out=10 one cycle, back to IDLE; next instruction proceeds.
- rst asserted in WAIT cycle 2 → dmem_req=0 and stall_out=0 immediately, invalid_out=1; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

    // Exception codes reported on exc_out
    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10,
        EXC_ILLEGAL  = 2'b11
    } exc_e;

    // Access sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte-enable masks at lane offset 0
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Lane mask a load touches, before shifting to its byte offset
    function automatic logic [3:0] load_mask(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: load_mask = BE_B;
            F3_LH, F3_LHU: load_mask = BE_H;
            default:       load_mask = BE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Sign- or zero-extend the selected lane according to the load type
    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LBU:  o_data = {24'h0, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LHU:  o_data = {16'h0, w_shifted[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores, stalls while the
// memory is busy, aborts on bus timeout and registers MEM/WB outputs.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    input  logic [3:0]  memwrite_in,
    input  logic [31:0] ALUout_in,
    input  logic [31:0] rdata2_in,
    input  logic        invalid_in,
    input  logic [31:0] immgen_in,
    input  logic [1:0]  regin_in,
    input  logic [31:0] PC_plus4_in,
    input  logic [31:0] inst_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_out,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [1:0]  regin_out,
    output logic [31:0] ALUout_out,
    output logic [31:0] immgen_out,
    output logic [31:0] PC_plus4_out,
    output logic [31:0] inst_data_out,
    output logic [31:0] load_data_out,
    output logic        invalid_out,
    output logic [1:0]  exc_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last WAIT cycle in which a late ready is still accepted
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;

    logic [2:0]  w_funct3;
    logic        w_store;
    logic        w_memop;
    logic        w_illegal;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_exc_in;
    logic        w_issue;
    logic        w_wait;
    logic        w_last;
    logic        w_timeout;
    logic        w_done;
    logic        w_stall;
    logic [3:0]  w_in_be;
    logic [31:0] w_in_wdata;
    logic [1:0]  w_cur_off;
    logic [2:0]  w_cur_f3;
    logic        w_cur_load;
    logic [31:0] w_load_data;

    // Decode of the instruction currently presented by EX/MEM
    assign w_funct3   = inst_data_in[14:12];
    assign w_store    = (memwrite_in != BE_NONE);
    assign w_memop    = !invalid_in && (memtoreg_in || w_store);
    assign w_illegal  = (memtoreg_in && w_store)
                     || !(memwrite_in inside {BE_NONE, BE_B, BE_H, BE_W})
                     || (memtoreg_in && (w_funct3 inside {3'b011, 3'b110, 3'b111}));
    assign w_is_half  = memtoreg_in ? (w_funct3 == F3_LH || w_funct3 == F3_LHU)
                                    : (memwrite_in == BE_H);
    assign w_is_word  = memtoreg_in ? (w_funct3 == F3_LW) : (memwrite_in == BE_W);
    assign w_misalign = (w_is_half && ALUout_in[0]) || (w_is_word && (ALUout_in[1:0] != 2'b00));

    // Exceptions are only raised for a fresh instruction seen in IDLE
    assign w_exc_in   = (r_state == IDLE) && w_memop && (w_illegal || w_misalign);
    assign w_issue    = (r_state == IDLE) && w_memop && !w_illegal && !w_misalign;
    assign w_wait     = (r_state == WAIT);
    assign w_last     = w_wait && (r_cnt == CNT_LAST);
    assign w_timeout  = w_last && !dmem_ready;
    assign w_done     = (w_issue || w_wait) && dmem_ready;
    // The final WAIT cycle never stalls: the instruction either completes
    // or is retired as a timeout, so EX/MEM must advance past it.
    assign w_stall    = (w_issue && !dmem_ready) || (w_wait && !dmem_ready && !w_last);

    assign w_in_be    = (w_store ? memwrite_in : load_mask(w_funct3)) << ALUout_in[1:0];
    assign w_in_wdata = w_store ? (rdata2_in << {ALUout_in[1:0], 3'b000}) : 32'h0;

    // Request fields come straight from the inputs when issuing, from the
    // latched copy while waiting so they stay stable for the memory.
    assign dmem_req   = !rst && (w_issue || w_wait);
    assign dmem_we    = w_wait ? r_we : (w_issue && w_store);
    assign dmem_addr  = w_wait ? {r_addr[31:2], 2'b00}
                               : (w_issue ? {ALUout_in[31:2], 2'b00} : 32'h0);
    assign dmem_be    = w_wait ? r_be : (w_issue ? w_in_be : 4'h0);
    assign dmem_wdata = w_wait ? r_wdata : (w_issue ? w_in_wdata : 32'h0);
    assign stall_out  = !rst && w_stall;

    assign w_cur_off  = w_wait ? r_addr[1:0] : ALUout_in[1:0];
    assign w_cur_f3   = w_wait ? r_funct3 : w_funct3;
    assign w_cur_load = w_wait ? !r_we : memtoreg_in;

    load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (w_cur_off),
        .i_funct3 (w_cur_f3),
        .o_data   (w_load_data)
    );

    // Access sequencer: latch a request that is not served immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue && !dmem_ready) begin
                        r_state  <= WAIT;
                        r_cnt    <= '0;
                        r_we     <= w_store;
                        r_addr   <= ALUout_in;
                        r_be     <= w_in_be;
                        r_wdata  <= w_in_wdata;
                        r_funct3 <= w_funct3;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmem_ready || w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // MEM/WB output register: bubble, exception or normal result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_out  <= 1'b0;
            memtoreg_out  <= 1'b0;
            regin_out     <= 2'b00;
            ALUout_out    <= 32'h0;
            immgen_out    <= 32'h0;
            PC_plus4_out  <= 32'h0;
            inst_data_out <= 32'h0;
            load_data_out <= 32'h0;
            invalid_out   <= 1'b1;
            exc_out       <= EXC_NONE;
        end else begin
            regin_out     <= regin_in;
            ALUout_out    <= ALUout_in;
            immgen_out    <= immgen_in;
            PC_plus4_out  <= PC_plus4_in;
            inst_data_out <= inst_data_in;
            load_data_out <= 32'h0;
            exc_out       <= EXC_NONE;
            if (w_stall) begin
                regwrite_out <= 1'b0;
                memtoreg_out <= 1'b0;
                invalid_out  <= 1'b1;
            end else if (w_timeout || w_exc_in) begin
                regwrite_out <= 1'b0;
                memtoreg_out <= 1'b0;
                invalid_out  <= 1'b1;
                if (w_timeout) begin
                    exc_out <= EXC_TIMEOUT;
                end else if (w_illegal) begin
                    exc_out <= EXC_ILLEGAL;
                end else begin
                    exc_out <= EXC_MISALIGN;
                end
            end else begin
                regwrite_out <= regwrite_in && !invalid_in;
                memtoreg_out <= memtoreg_in && !invalid_in;
                invalid_out  <= invalid_in;
                if (w_done && w_cur_load) begin
                    load_data_out <= w_load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoreg_in, regwrite_in, invalid_in;
    logic [3:0]  memwrite_in;
    logic [31:0] ALUout_in, rdata2_in, immgen_in, PC_plus4_in, inst_data_in;
    logic [1:0]  regin_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_out, regwrite_out, memtoreg_out, invalid_out;
    logic [1:0]  regin_out, exc_out;
    logic [31:0] ALUout_out, immgen_out, PC_plus4_out, inst_data_out, load_data_out;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .memwrite_in(memwrite_in),
        .ALUout_in(ALUout_in), .rdata2_in(rdata2_in), .invalid_in(invalid_in),
        .immgen_in(immgen_in), .regin_in(regin_in), .PC_plus4_in(PC_plus4_in),
        .inst_data_in(inst_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall_out(stall_out), .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
        .regin_out(regin_out), .ALUout_out(ALUout_out), .immgen_out(immgen_out),
        .PC_plus4_out(PC_plus4_out), .inst_data_out(inst_data_out),
        .load_data_out(load_data_out), .invalid_out(invalid_out), .exc_out(exc_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Architectural result of a load: pick the lane, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) % 256;
        h = (rdata >> (8 * off)) % 65536;
        case (f3)
            3'd0:    ref_load = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    ref_load = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    ref_load = b;
            3'd5:    ref_load = h;
            default: ref_load = rdata;
        endcase
    endfunction

    // One instruction held at the stage until it retires; memory answers
    // 'delay' cycles after the request first appears.
    task automatic run_op(input logic mtr, input logic rw, input logic [3:0] mw,
                          input logic [31:0] addr, input logic [31:0] d2, input logic inv,
                          input logic [2:0] f3, input logic [31:0] rdata, input int delay);
        logic [31:0] inst, imm, pc;
        logic [1:0]  rg;
        logic [1:0]  exp_exc;
        int  sz, off, k;
        bit  ill, mis, memop, acc, done, exp_stall, rdy;
        inst = $urandom; inst[14:12] = f3;
        imm  = $urandom; pc = $urandom; rg = 2'($urandom);
        memop = !inv && (mtr || mw != 4'd0);
        ill = 1'b0; sz = 1;
        if (mtr && mw != 4'd0) ill = 1'b1;
        else if (mtr) begin
            case (f3)
                3'd0, 3'd4: sz = 1;
                3'd1, 3'd5: sz = 2;
                3'd2:       sz = 4;
                default:    ill = 1'b1;
            endcase
        end else begin
            case (mw)
                4'd0, 4'd1: sz = 1;
                4'd3:       sz = 2;
                4'd15:      sz = 4;
                default:    ill = 1'b1;
            endcase
        end
        off = int'(addr % 4);
        mis = !ill && (addr % sz != 0);
        acc = memop && !ill && !mis;
        if (memop && ill)                   exp_exc = 2'd3;
        else if (memop && mis)              exp_exc = 2'd1;
        else if (acc && delay > TIMEOUT)    exp_exc = 2'd2;
        else                                exp_exc = 2'd0;
        k = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            memtoreg_in = mtr; regwrite_in = rw; memwrite_in = mw; ALUout_in = addr;
            rdata2_in = d2; invalid_in = inv; immgen_in = imm; regin_in = rg;
            PC_plus4_in = pc; inst_data_in = inst;
            rdy = acc ? (k >= delay) : 1'($urandom);
            dmem_ready = rdy;
            dmem_rdata = (acc && k >= delay) ? rdata : $urandom;
            #1;
            check_val("req", dmem_req, acc);
            if (acc) begin
                check_val("addr", dmem_addr, addr - off);
                check_val("we", dmem_we, mw != 4'd0);
                if (mw != 4'd0) begin
                    check_val("be", dmem_be, (32'(mw) << off) % 16);
                    check_val("wdata", dmem_wdata, d2 << (8 * off));
                end
            end
            exp_stall = acc && !rdy && (k < TIMEOUT);
            check_val("stall", stall_out, exp_stall);
            @(posedge clk); #1;
            if (exp_stall) begin
                check_val("bubble_inv", invalid_out, 1);
                check_val("bubble_rw", regwrite_out, 0);
                check_val("bubble_mtr", memtoreg_out, 0);
                k++;
            end else begin
                done = 1'b1;
                check_val("exc", exc_out, exp_exc);
                if (exp_exc != 2'd0) begin
                    check_val("exc_inv", invalid_out, 1);
                    check_val("exc_rw", regwrite_out, 0);
                end else begin
                    check_val("inv", invalid_out, inv);
                    check_val("rw", regwrite_out, rw && !inv);
                    check_val("mtr", memtoreg_out, mtr && !inv);
                    check_val("alu", ALUout_out, addr);
                    check_val("imm", immgen_out, imm);
                    check_val("pc4", PC_plus4_out, pc);
                    check_val("inst", inst_data_out, inst);
                    check_val("regin", regin_out, rg);
                    if (acc && mtr) check_val("ldata", load_data_out, ref_load(rdata, off, f3));
                end
            end
        end
        $display("op mtr=%0d mw=%b addr=%08h f3=%0d inv=%0d delay=%0d exc=%0d stalls=%0d",
                 mtr, mw, addr, f3, inv, delay, exp_exc, k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a legal load presented: nothing may be requested
        rst = 1'b1; memtoreg_in = 1'b1; regwrite_in = 1'b1; memwrite_in = 4'd0;
        ALUout_in = 32'h100; rdata2_in = 0; invalid_in = 1'b0; immgen_in = 0;
        regin_in = 0; PC_plus4_in = 0; inst_data_in = 32'h0000_2000; dmem_ready = 1'b0;
        dmem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_req", dmem_req, 0);
        check_val("rst_stall", stall_out, 0);
        check_val("rst_inv", invalid_out, 1);
        check_val("rst_rw", regwrite_out, 0);
        check_val("rst_exc", exc_out, 0);
        check_val("rst_alu", ALUout_out, 0);
        invalid_in = 1'b1;
        rst = 1'b0;

        run_op(1, 1, 4'd0, 32'h100, 0, 0, 3'd2, 32'hDEADBEEF, 0);   // LW
        run_op(1, 1, 4'd0, 32'h103, 0, 0, 3'd0, 32'h80FF0000, 0);   // LB
        run_op(1, 1, 4'd0, 32'h103, 0, 0, 3'd4, 32'h80FF0000, 0);   // LBU
        run_op(1, 1, 4'd0, 32'h102, 0, 0, 3'd1, 32'h80FF0000, 0);   // LH
        run_op(1, 1, 4'd0, 32'h102, 0, 0, 3'd5, 32'h80FF0000, 2);   // LHU
        run_op(0, 0, 4'd3, 32'h202, 32'h0000ABCD, 0, 3'd0, 0, 3);   // SH
        run_op(0, 0, 4'd1, 32'h301, 32'h0000005A, 0, 3'd0, 0, 1);   // SB
        run_op(1, 1, 4'd0, 32'h101, 0, 0, 3'd2, 0, 0);              // LW misaligned
        run_op(0, 0, 4'd15, 32'h106, 32'h12345678, 0, 3'd0, 0, 0);  // SW misaligned
        run_op(1, 1, 4'd0, 32'h201, 0, 0, 3'd1, 0, 0);              // LH misaligned
        run_op(1, 1, 4'd1, 32'h200, 0, 0, 3'd0, 0, 0);              // load+store illegal
        run_op(0, 0, 4'd5, 32'h200, 0, 0, 3'd0, 0, 0);              // bad mask
        run_op(1, 1, 4'd0, 32'h200, 0, 0, 3'd3, 0, 0);              // bad funct3
        run_op(1, 1, 4'd0, 32'h400, 0, 0, 3'd2, 32'h1, 100);        // timeout
        run_op(1, 1, 4'd0, 32'h404, 0, 0, 3'd2, 32'hCAFEF00D, 1);   // proceeds after
        run_op(1, 1, 4'd0, 32'h408, 0, 0, 3'd2, 32'h11223344, TIMEOUT);     // ready on last cycle
        run_op(1, 1, 4'd0, 32'h40C, 0, 0, 3'd2, 32'h55667788, TIMEOUT + 1); // just too late
        run_op(1, 1, 4'd0, 32'h410, 0, 1, 3'd2, 0, 0);              // bubble in
        run_op(0, 1, 4'd0, 32'h12345677, 0, 0, 3'd0, 0, 0);         // ALU op

        // Reset in the second WAIT cycle of a pending load
        @(negedge clk);
        memtoreg_in = 1'b1; regwrite_in = 1'b1; memwrite_in = 4'd0; ALUout_in = 32'h300;
        invalid_in = 1'b0; inst_data_in = 32'h0000_2000; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("wait_req", dmem_req, 1);
        check_val("wait_stall", stall_out, 1);
        rst = 1'b1;
        #1;
        check_val("midrst_req", dmem_req, 0);
        check_val("midrst_stall", stall_out, 0);
        check_val("midrst_inv", invalid_out, 1);
        check_val("midrst_rw", regwrite_out, 0);
        invalid_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 1, 4'd0, 32'h500, 0, 0, 3'd2, 32'hA5A5_5A5A, 0);

        // Random mix of ALU ops, loads, stores, bad encodings and latencies
        for (int i = 0; i < 250; i++) begin
            logic        mtr, rw, inv;
            logic [3:0]  mw;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          kind, delay;
            logic [3:0]  smask [3];
            logic [2:0]  lf3 [5];
            smask = '{4'd1, 4'd3, 4'd15};
            lf3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            kind = $urandom_range(0, 5);
            rw = 1'($urandom);
            mtr = 1'b0; mw = 4'd0;
            case (kind)
                0:       ;
                1, 2:    mtr = 1'b1;
                3, 4:    mw = smask[$urandom_range(0, 2)];
                default: begin mtr = 1'($urandom); mw = 4'($urandom); end
            endcase
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : lf3[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            inv = ($urandom_range(0, 9) == 0);
            delay = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
            run_op(mtr, rw, mw, addr, $urandom, inv, f3, $urandom, delay);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
